// File: rtl/control_nueva_ficha.sv
// control_nueva_ficha: inserts a new tile (2 or 4) into a random empty cell
// of the 4x4 board.
//
// On start, the block latches the board and scans its 16 cells one per cycle,
// building a list of the empty cells. An LFSR value is then reduced modulo the
// number of empty cells to pick one entry from that list.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   start          insertion request, sampled only in IDLE
//   matriz_entrada current board (0 = empty), cell index = 4*i + j
//   matriz_salida  board after insertion, held until the next result
//   ocupado        busy, from the cycle after start until done falls
//   done           one-cycle pulse when the results are valid
//   sin_espacio    with done: board was full and nothing was written
//   posicion       cell index written by the last successful insertion
//   contador       number of empty cells found in the last scan
module control_nueva_ficha #(
   parameter logic [15:0] SEMILLA = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] matriz_entrada [4][4],
   output logic [31:0] matriz_salida  [4][4],
   output logic        ocupado,
   output logic        done,
   output logic        sin_espacio,
   output logic [3:0]  posicion,
   output logic [4:0]  contador
);

   typedef enum logic [2:0] {
      StIdle,
      StScan,
      StSelect,
      StReduce,
      StWrite,
      StDone
   } estado_e;

   estado_e            estado_q;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [15:0][31:0]  tablero_q;   // latched copy of the input board
   logic [15:0][31:0]  salida_q;
   logic [15:0][3:0]   lista_q;     // indices of the empty cells, in scan order
   logic [3:0]         k_q;
   logic [4:0]         cuenta_q;
   logic [3:0]         r_q;
   logic               cuatro_q;    // selected tile is a 4 rather than a 2
   logic               ocupado_q, done_q, sin_q;
   logic [3:0]         posicion_q;
   logic [4:0]         contador_q;
   logic [31:0]        valor;

   // Fibonacci LFSR, taps 16/14/13/11, shifting left into bit 0.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign valor  = cuatro_q ? 32'd4 : 32'd2;

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= StIdle;
         lfsr_q     <= SEMILLA;
         tablero_q  <= '0;
         salida_q   <= '0;
         lista_q    <= '0;
         k_q        <= '0;
         cuenta_q   <= '0;
         r_q        <= '0;
         cuatro_q   <= 1'b0;
         ocupado_q  <= 1'b0;
         done_q     <= 1'b0;
         sin_q      <= 1'b0;
         posicion_q <= '0;
         contador_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         done_q <= 1'b0;
         unique case (estado_q)
            StIdle: begin
               if (start) begin
                  for (int i = 0; i < 4; i++) begin
                     for (int j = 0; j < 4; j++) begin
                        tablero_q[4*i+j] <= matriz_entrada[i][j];
                     end
                  end
                  k_q       <= '0;
                  cuenta_q  <= '0;
                  ocupado_q <= 1'b1;
                  estado_q  <= StScan;
               end
            end
            StScan: begin
               if (tablero_q[k_q] == 32'd0) begin
                  lista_q[cuenta_q[3:0]] <= k_q;
                  cuenta_q               <= cuenta_q + 5'd1;
               end
               k_q <= k_q + 4'd1;
               if (k_q == 4'd15) begin
                  estado_q <= StSelect;
               end
            end
            StSelect: begin
               contador_q <= cuenta_q;
               if (cuenta_q == 5'd0) begin
                  salida_q <= tablero_q;
                  sin_q    <= 1'b1;
                  done_q   <= 1'b1;
                  estado_q <= StDone;
               end else begin
                  r_q      <= lfsr_q[3:0];
                  cuatro_q <= (lfsr_q[7:5] == 3'b000);
                  sin_q    <= 1'b0;
                  estado_q <= StReduce;
               end
            end
            StReduce: begin
               // Repeated subtraction: r mod count in at most 16 cycles.
               // r >= count implies count <= 15, so the low 4 bits suffice.
               if ({1'b0, r_q} >= cuenta_q) begin
                  r_q <= r_q - cuenta_q[3:0];
               end else begin
                  estado_q <= StWrite;
               end
            end
            StWrite: begin
               for (int c = 0; c < 16; c++) begin
                  salida_q[c] <= (4'(c) == lista_q[r_q]) ? valor : tablero_q[c];
               end
               posicion_q <= lista_q[r_q];
               done_q     <= 1'b1;
               estado_q   <= StDone;
            end
            StDone: begin
               ocupado_q <= 1'b0;
               estado_q  <= StIdle;
            end
            default: begin
               estado_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            matriz_salida[i][j] = salida_q[4*i+j];
         end
      end
   end

   assign ocupado     = ocupado_q;
   assign done        = done_q;
   assign sin_espacio = sin_q;
   assign posicion    = posicion_q;
   assign contador    = contador_q;

endmodule

// File: tb/tb_control_nueva_ficha.sv
// Testbench for control_nueva_ficha: scoreboard of expected results built
// from an independent LFSR/selection model, compared when done pulses.
module tb_control_nueva_ficha;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] ent [4][4];
   logic [31:0] sal [4][4];
   logic        ocupado, done, sin_espacio;
   logic [3:0]  posicion;
   logic [4:0]  contador;

   control_nueva_ficha #(.SEMILLA(SEED)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .matriz_entrada (ent),
      .matriz_salida  (sal),
      .ocupado        (ocupado),
      .done           (done),
      .sin_espacio    (sin_espacio),
      .posicion       (posicion),
      .contador       (contador)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0][31:0] tab;
      logic [3:0]        pos;
      logic [4:0]        cnt;
      logic              sin;
      int                lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic [3:0] prev_pos = 4'd0;
   int   n_four = 0;
   int   n_writes = 0;

   // Reference LFSR, advanced on every non-reset edge just like the DUT's.
   logic [15:0] m_lfsr;

   function automatic logic [15:0] step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= step(m_lfsr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int c = 0; c < 16; c++) check({tag, "_cell"}, sal[c/4][c%4], 32'd0);
      check({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_sin"}, {31'd0, sin_espacio}, 32'd0);
      check({tag, "_pos"}, {28'd0, posicion}, 32'd0);
      check({tag, "_cnt"}, {27'd0, contador}, 32'd0);
   endtask

   // One request: build expectation, push, drive, wait for done, pop, compare.
   // With spam set, start stays high and the input board is scrambled while busy.
   task automatic run_req(input logic [15:0][31:0] b, input bit spam);
      exp_t        e;
      exp_t        g;
      logic [15:0] l;
      logic [3:0]  lst [16];
      int          cnt;
      int          r0;
      int          cyc;
      @(negedge clk);
      for (int c = 0; c < 16; c++) ent[c/4][c%4] = b[c];
      // DUT's LFSR at SELECT is 17 steps past its value at the start edge.
      l = m_lfsr;
      repeat (17) l = step(l);
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (b[c] == 32'd0) begin
            lst[cnt] = 4'(c);
            cnt++;
         end
      end
      e.tab = b;
      e.cnt = 5'(cnt);
      if (cnt == 0) begin
         e.sin = 1'b1;
         e.pos = prev_pos;
         e.lat = 17;
      end else begin
         r0    = int'(l[3:0]);
         e.sin = 1'b0;
         e.pos = lst[r0 % cnt];
         e.tab[e.pos] = (l[7:5] == 3'b000) ? 32'd4 : 32'd2;
         e.lat = 19 + r0 / cnt;
      end
      sb.push_back(e);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = spam;
      if (spam) begin
         for (int c = 0; c < 16; c++) ent[c/4][c%4] = 32'd0;
      end
      cyc = 0;
      while (!done && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) check("ocupado_busy", {31'd0, ocupado}, 32'd1);
      end
      start = 1'b0;
      g = sb.pop_front();
      check("latency", cyc, g.lat);
      for (int c = 0; c < 16; c++) check("cell", sal[c/4][c%4], g.tab[c]);
      check("sin_espacio", {31'd0, sin_espacio}, {31'd0, g.sin});
      check("contador", {27'd0, contador}, {27'd0, g.cnt});
      check("posicion", {28'd0, posicion}, {28'd0, g.pos});
      check("ocupado_at_done", {31'd0, ocupado}, 32'd1);
      if (!g.sin) begin
         n_writes++;
         if (g.tab[g.pos] == 32'd4) n_four++;
      end
      prev_pos = g.pos;
      @(posedge clk);
      #1;
      check("done_pulse", {31'd0, done}, 32'd0);
      check("ocupado_drop", {31'd0, ocupado}, 32'd0);
   endtask

   logic [15:0][31:0] bd;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int c = 0; c < 16; c++) ent[c/4][c%4] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Full board.
      for (int c = 0; c < 16; c++) bd[c] = 32'd2;
      run_req(bd, 1'b0);

      // Single empty cell at index 5.
      for (int c = 0; c < 16; c++) bd[c] = 32'd8;
      bd[5] = 32'd0;
      run_req(bd, 1'b0);

      // Reset asserted so that it is sampled at E8, mid-scan.
      @(negedge clk);
      for (int c = 0; c < 16; c++) ent[c/4][c%4] = 32'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midscan_rst");
      @(negedge clk);
      rst      = 1'b0;
      prev_pos = 4'd0;
      repeat (3) @(posedge clk);

      // All-zero board shortly after reset release.
      bd = '0;
      run_req(bd, 1'b0);

      // Zeros at 0, 7, 15 with start held while busy.
      for (int c = 0; c < 16; c++) bd[c] = 32'd16;
      bd[0]  = 32'd0;
      bd[7]  = 32'd0;
      bd[15] = 32'd0;
      run_req(bd, 1'b1);

      // Random boards.
      n_four   = 0;
      n_writes = 0;
      for (int t = 0; t < 1000; t++) begin
         for (int c = 0; c < 16; c++) begin
            if ((t % 10) != 0 && $urandom_range(0, 1) == 0) bd[c] = 32'd0;
            else bd[c] = 32'd2 << $urandom_range(0, 10);
         end
         run_req(bd, 1'b0);
      end
      // Tile value 4 should appear roughly one time in eight.
      check("freq4", {31'd0, (n_four * 8 > n_writes / 2) && (n_four * 8 < n_writes * 2)}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
